anti_theft_timer: RTL and testbench

ANTI_THEFT_TIMER -- requirements
Module: anti_theft_timer

---
 rtl/anti_theft_timer_pkg.sv | 22 ++
 rtl/anti_theft_timer_time_parameters.sv | 41 ++++
 rtl/anti_theft_timer.sv | 119 +++++++++++
 tb/tb_anti_theft_timer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/anti_theft_timer_pkg.sv
// Shared encodings and default times for the anti-theft timer and the alarm FSM that drives it.
package anti_theft_timer_pkg;

  typedef enum logic [1:0] {
    INT_ARM       = 2'b00,
    INT_DRIVER    = 2'b01,
    INT_PASSENGER = 2'b10,
    INT_ALARM     = 2'b11
  } interval_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } timer_state_e;

  localparam int unsigned DEF_T_ARM = 6;
  localparam int unsigned DEF_T_DRV = 8;
  localparam int unsigned DEF_T_PAS = 15;
  localparam int unsigned DEF_T_ALM = 10;

endpackage

// File: rtl/anti_theft_timer_time_parameters.sv
// Four writable 4-bit time parameters (seconds) with a combinational read selected by interval.
module time_parameters
  import anti_theft_timer_pkg::*;
#(
  parameter int unsigned T_ARM_DEF = DEF_T_ARM,
  parameter int unsigned T_DRV_DEF = DEF_T_DRV,
  parameter int unsigned T_PAS_DEF = DEF_T_PAS,
  parameter int unsigned T_ALM_DEF = DEF_T_ALM
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic [1:0] interval,
  output logic [3:0] value
);

  logic [3:0] param_q [4];
  logic [3:0] param_d [4];

  always_comb begin
    param_d = param_q;
    if (reprogram) param_d[time_param_sel] = time_value;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      param_q[INT_ARM]       <= 4'(T_ARM_DEF);
      param_q[INT_DRIVER]    <= 4'(T_DRV_DEF);
      param_q[INT_PASSENGER] <= 4'(T_PAS_DEF);
      param_q[INT_ALARM]     <= 4'(T_ALM_DEF);
    end else begin
      param_q <= param_d;
    end
  end

  // Read the registered value so a same-edge write never reaches a load.
  assign value = param_q[interval];

endmodule

// File: rtl/anti_theft_timer.sv
// Seconds countdown timer for the alarm FSM: 1 Hz divider, load/abort detection and expiry pulse.
//   state    | meaning
//   ST_IDLE  | no timing requested, remaining held at 0
//   ST_COUNT | counting down remaining on each 1 Hz tick
//   ST_DONE  | timing ended, expired already pulsed, waiting for abort or reload
module anti_theft_timer
  import anti_theft_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned T_ARM_DEF = 6,
  parameter int unsigned T_DRV_DEF = 8,
  parameter int unsigned T_PAS_DEF = 15,
  parameter int unsigned T_ALM_DEF = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       one_hz_enable,
  output logic [3:0] remaining
);

  localparam int unsigned DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

  timer_state_e     state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             expired_q, expired_d;
  logic             one_hz_q, one_hz_d;
  logic             start_q, start_d;
  logic [1:0]       interval_q, interval_d;
  logic [3:0]       load_value;
  logic             tick;
  logic             load;

  time_parameters #(
    .T_ARM_DEF (T_ARM_DEF),
    .T_DRV_DEF (T_DRV_DEF),
    .T_PAS_DEF (T_PAS_DEF),
    .T_ALM_DEF (T_ALM_DEF)
  ) u_time_parameters (
    .clock          (clock),
    .reset          (reset),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .interval       (interval),
    .value          (load_value)
  );

  always_comb begin
    start_d     = start_timer;
    interval_d  = interval;
    tick        = (div_q == DIV_LAST);
    load        = start_timer && (!start_q || (interval != interval_q));
    div_d       = tick ? '0 : div_q + 1'b1;
    one_hz_d    = tick && !load;
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;

    if (load) begin
      div_d       = '0;
      remaining_d = load_value;
      state_d     = ST_COUNT;
    end else if (!start_timer) begin
      remaining_d = '0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_COUNT: begin
          // A zero load expires immediately; otherwise expire on the tick that reaches 0.
          if (remaining_q == 4'd0) begin
            expired_d = 1'b1;
            state_d   = ST_DONE;
          end else if (tick) begin
            remaining_d = remaining_q - 4'd1;
            if (remaining_q == 4'd1) begin
              expired_d = 1'b1;
              state_d   = ST_DONE;
            end
          end
        end
        ST_DONE: remaining_d = '0;
        default: remaining_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      remaining_q <= '0;
      expired_q   <= 1'b0;
      one_hz_q    <= 1'b0;
      start_q     <= 1'b0;
      interval_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      one_hz_q    <= one_hz_d;
      start_q     <= start_d;
      interval_q  <= interval_d;
    end
  end

  assign expired       = expired_q;
  assign one_hz_enable = one_hz_q;
  assign remaining     = remaining_q;

endmodule

// File: tb/tb_anti_theft_timer.sv
// Directed bench for anti_theft_timer at CLK_FREQ=4; inputs driven and outputs sampled on the falling edge.
module tb_anti_theft_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic [3:0] remaining;

  int errors = 0;
  int checks = 0;

  anti_theft_timer #(.CLK_FREQ(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .interval       (interval),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .remaining      (remaining)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start_timer = 1'b0; interval = 2'b00;
    reprogram = 1'b0; time_param_sel = 2'b00; time_value = 4'd0;
    repeat (2) @(negedge clock);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_expired", 32'(expired), 0);
    chk("rst_one_hz", 32'(one_hz_enable), 0);
    reset = 1'b0;

    // Driver timing: 8 s at 4 cycles/s, expiry 32 edges after the load edge.
    start_timer = 1'b1; interval = 2'b01;
    @(negedge clock);
    chk("a_load_rem", 32'(remaining), 8);
    chk("a_load_exp", 32'(expired), 0);
    for (int e = 1; e <= 32; e++) begin
      @(negedge clock);
      chk("a_rem", 32'(remaining), 32'(8 - e / 4));
      chk("a_exp", 32'(expired), 32'(e == 32));
      chk("a_one_hz", 32'(one_hz_enable), 32'((e % 4) == 0));
    end
    for (int e = 0; e < 6; e++) begin
      @(negedge clock);
      chk("a_done_exp", 32'(expired), 0);
      chk("a_done_rem", 32'(remaining), 0);
    end
    start_timer = 1'b0;
    @(negedge clock);
    chk("a_idle_rem", 32'(remaining), 0);

    // Passenger reprogrammed to 3 s: expiry 12 edges after load.
    reprogram = 1'b1; time_param_sel = 2'b10; time_value = 4'd3;
    @(negedge clock);
    reprogram = 1'b0;
    start_timer = 1'b1; interval = 2'b10;
    @(negedge clock);
    chk("b_load_rem", 32'(remaining), 3);
    for (int e = 1; e <= 12; e++) begin
      @(negedge clock);
      chk("b_exp", 32'(expired), 32'(e == 12));
    end
    start_timer = 1'b0;
    @(negedge clock);

    // Interval switch to alarm at edge 10 reloads 10 s.
    start_timer = 1'b1; interval = 2'b01;
    @(negedge clock);
    repeat (9) @(negedge clock);
    chk("c_pre_rem", 32'(remaining), 6);
    interval = 2'b11;
    @(negedge clock);
    chk("c_reload_rem", 32'(remaining), 10);
    for (int f = 1; f <= 40; f++) begin
      @(negedge clock);
      chk("c_exp", 32'(expired), 32'(f == 40));
      if (f == 20) chk("c_mid_rem", 32'(remaining), 5);
    end
    start_timer = 1'b0;
    @(negedge clock);

    // Abort at edge 7: idle, no expiry.
    start_timer = 1'b1; interval = 2'b01;
    @(negedge clock);
    repeat (6) @(negedge clock);
    start_timer = 1'b0;
    @(negedge clock);
    chk("d_abort_rem", 32'(remaining), 0);
    for (int e = 0; e < 40; e++) begin
      @(negedge clock);
      chk("d_no_exp", 32'(expired), 0);
    end

    // Zero arm time: expiry on the cycle after the load, once.
    reprogram = 1'b1; time_param_sel = 2'b00; time_value = 4'd0;
    @(negedge clock);
    reprogram = 1'b0;
    start_timer = 1'b1; interval = 2'b00;
    @(negedge clock);
    chk("e_load_rem", 32'(remaining), 0);
    chk("e_load_exp", 32'(expired), 0);
    @(negedge clock);
    chk("e_exp", 32'(expired), 1);
    @(negedge clock);
    chk("e_exp_once", 32'(expired), 0);
    start_timer = 1'b0;
    @(negedge clock);

    // Same-edge reprogram and load: load sees the old value; running count unaffected.
    reprogram = 1'b1; time_param_sel = 2'b01; time_value = 4'd2;
    start_timer = 1'b1; interval = 2'b01;
    @(negedge clock);
    reprogram = 1'b0;
    chk("e_old_val", 32'(remaining), 8);
    @(negedge clock);
    chk("e_no_change", 32'(remaining), 8);
    start_timer = 1'b0;
    @(negedge clock);
    start_timer = 1'b1;
    @(negedge clock);
    chk("e_new_val", 32'(remaining), 2);

    // Reset mid-count with start held high: outputs clear, defaults restored, rise re-detected.
    repeat (3) @(negedge clock);
    chk("f_pre_rem", 32'(remaining), 2);
    reset = 1'b1;
    @(negedge clock);
    chk("f_rst_rem", 32'(remaining), 0);
    chk("f_rst_exp", 32'(expired), 0);
    chk("f_rst_one_hz", 32'(one_hz_enable), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("f_drv_def", 32'(remaining), 8);
    interval = 2'b00;
    @(negedge clock);
    chk("f_arm_def", 32'(remaining), 6);
    interval = 2'b10;
    @(negedge clock);
    chk("f_pas_def", 32'(remaining), 15);
    interval = 2'b11;
    @(negedge clock);
    chk("f_alm_def", 32'(remaining), 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
